fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage of the RV32I pipeline.
- Owns the program counter and the instruction-memory request handshake, and loads the IF/ID pipeline register.
- Acts on the 2-bit PC select code and flush produced by the branch/jump resolution logic in EX: redirects the PC, squashes wrong-path instructions, and returns the is_flushed indication to that logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven into IF/ID when it holds a bubble (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- pc_sel  in  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR target
- flush  in  1  redirect taken; squash the IF/ID contents
- branch_target  in  32  PC+imm for B-type
- jal_target  in  32  PC+imm for JAL
- jalr_target  in  32  rs1+imm for JALR (bit0 cleared here)
- stall  in  1  load-use hold from the hazard unit
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  completes the request this cycle
- ifid_pc  out  32  PC of the IF/ID instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- is_flushed  out  1  IF/ID bubble caused by a flush
- misalign_err  out  1  sticky: redirect target not word-aligned

Behaviour:
- Reset: rst is synchronous, active-high.
  - pc=RESET_PC, state=RUN, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, is_flushed=0, misalign_err=0.
  - imem_req=0 while rst=1.
  - rst overrides every other input, including mid-handshake.
- State RUN:
  - imem_req=1, imem_addr=pc.
  - Address stability rule: imem_addr stays unchanged while imem_req=1 and imem_ready=0.
- Redirect target:
  - pc_sel 01 selects branch_target; 10 selects jal_target; 11 selects {jalr_target[31:1],1'b0}.
  - If the selected target has bits[1:0]!=0: misalign_err<=1 and state<=ERROR.
- Priority within a cycle: flush > stall > normal.
- flush=1 in RUN:
  - Target aligned and imem_ready=1: pc<=target.
  - Target aligned and imem_ready=0: pend_pc<=target, state<=DRAIN. pc and imem_addr stay held.
  - In both cases: ifid_valid<=0, ifid_instr<=NOP_INSTR, is_flushed<=1.
  - A same-cycle imem_rdata is discarded.
  - flush=1 with pc_sel=00 is treated as target=pc+4.
- stall=1 (no flush):
  - pc, ifid_* and is_flushed hold.
  - imem_req stays 1. A response arriving with imem_ready=1 is discarded, and the same pc is refetched.
- Normal path (no flush, no stall):
  - imem_ready=1: ifid_pc<=pc, ifid_instr<=imem_rdata, ifid_valid<=1, is_flushed<=0, pc<=pc+4.
  - imem_ready=0: ifid_valid<=0, ifid_instr<=NOP_INSTR, is_flushed<=0, pc holds.
- State DRAIN:
  - imem_req=1 at the old address.
  - On imem_ready=1: the data is discarded, pc<=pend_pc, state<=RUN.
  - A new flush in DRAIN overwrites pend_pc; the latest redirect wins.
  - IF/ID keeps inserting bubbles (valid=0); is_flushed=1 only in the cycle after a flush.
- State ERROR:
  - imem_req=0, ifid_valid=0, misalign_err=1.
  - Exit only via rst.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Latency: instruction address is presented in cycle N; with ready in N, IF/ID is valid in N+1. A redirect in cycle N fetches the target in N+1, giving a 1-bubble penalty.

Decomposition:
- Shared package (rv32_pkg): PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JAL=2'b10, PC_SEL_JALR=2'b11; NOP_INSTR; RESET_PC default; fetch state encoding RUN/DRAIN/ERROR.
- Sub-module next_pc_mux (combinational): takes pc, pc_sel and the three targets; returns the target and a misaligned flag. The FSM and registers stay in fetch_unit.

Test Plan:
- Reset, then imem_ready=1 continuously with rdata=addr^32'hA5A5_A5A5 -> addresses 0,4,8,C in consecutive cycles; ifid_valid=1 from cycle 2; ifid_pc tracks.
- At pc=0x10, flush=1, pc_sel=01, branch_target=0x40, imem_ready=1 -> next imem_addr=0x40; ifid_valid=0, is_flushed=1 for one cycle; the 0x10 data never appears in IF/ID.
- pc_sel=11, jalr_target=0x101, flush=1 -> fetch at 0x100, misalign_err=0. Then pc_sel=10, jal_target=0x102, flush=1 -> misalign_err=1, imem_req=0 until rst.
- imem_ready=0 for 3 cycles at 0x20 while flush with jal_target=0x80 arrives in cycle 1 -> imem_addr stays 0x20 until ready, that response is discarded, next address 0x80.
- stall=1 for 2 cycles with ifid_pc=0x8 -> ifid_pc/ifid_instr hold and pc holds. Same-cycle flush+stall -> flush wins, redirect taken.
- pc=0xFFFF_FFFC, ready=1 -> next imem_addr=0x0. rst asserted in DRAIN -> imem_addr=RESET_PC next cycle and pend_pc is ignored.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline constants: PC select codes, fetch FSM encoding and reset defaults.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JAL  = 2'b10;
  localparam logic [1:0] PC_SEL_JALR = 2'b11;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_DRAIN = 2'd1,
    FETCH_ERROR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Selects the next fetch target from the PC select code and flags word misalignment.
module next_pc_mux
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      pc_sel_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jal_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  always_comb begin
    target_o = pc_i + XLEN'(4);
    unique case (pc_sel_i)
      PC_SEL_SEQ:  target_o = pc_i + XLEN'(4);
      PC_SEL_BR:   target_o = branch_target_i;
      PC_SEL_JAL:  target_o = jal_target_i;
      PC_SEL_JALR: target_o = jalr_target_i & ~XLEN'(1);
      default:     target_o = pc_i + XLEN'(4);
    endcase
  end

  // JALR bit 0 is already cleared, so bit 1 alone decides for that case.
  assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/fetch_unit.sv
// RV32I IF stage: owns the PC, drives the imem request handshake and loads IF/ID,
// honouring redirects/flushes from EX and load-use stalls from the hazard unit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        is_flushed,
  output logic        misalign_err
);
  import rv32_pkg::*;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [XLEN-1:0] ifid_instr_q;
  logic            ifid_valid_q;
  logic            is_flushed_q;
  logic            misalign_err_q;

  logic [XLEN-1:0] target;
  logic            target_misaligned;

  next_pc_mux u_next_pc_mux (
    .pc_i            (pc_q),
    .pc_sel_i        (pc_sel),
    .branch_target_i (branch_target),
    .jal_target_i    (jal_target),
    .jalr_target_i   (jalr_target),
    .target_o        (target),
    .misaligned_o    (target_misaligned)
  );

  // Request drops during reset and once a misaligned redirect has parked the unit.
  assign imem_req     = !rst && (state_q != FETCH_ERROR);
  assign imem_addr    = pc_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_valid   = ifid_valid_q;
  assign is_flushed   = is_flushed_q;
  assign misalign_err = misalign_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH_RUN;
      pc_q           <= RESET_PC;
      pend_pc_q      <= RESET_PC;
      ifid_pc_q      <= '0;
      ifid_instr_q   <= NOP_INSTR;
      ifid_valid_q   <= 1'b0;
      is_flushed_q   <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH_RUN: begin
          if (flush) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            if (target_misaligned) begin
              is_flushed_q   <= 1'b0;
              misalign_err_q <= 1'b1;
              state_q        <= FETCH_ERROR;
            end else begin
              is_flushed_q <= 1'b1;
              if (imem_ready) begin
                pc_q <= target;
              end else begin
                // Address must stay stable until the outstanding request completes.
                pend_pc_q <= target;
                state_q   <= FETCH_DRAIN;
              end
            end
          end else if (stall) begin
            // Hold everything; any response this cycle is dropped and refetched.
          end else if (imem_ready) begin
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= imem_rdata;
            ifid_valid_q <= 1'b1;
            is_flushed_q <= 1'b0;
            pc_q         <= pc_q + XLEN'(4);
          end else begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            is_flushed_q <= 1'b0;
          end
        end

        FETCH_DRAIN: begin
          ifid_valid_q <= 1'b0;
          ifid_instr_q <= NOP_INSTR;
          is_flushed_q <= 1'b0;
          if (flush) begin
            if (target_misaligned) begin
              misalign_err_q <= 1'b1;
              state_q        <= FETCH_ERROR;
            end else begin
              is_flushed_q <= 1'b1;
              if (imem_ready) begin
                pc_q    <= target;
                state_q <= FETCH_RUN;
              end else begin
                pend_pc_q <= target;
              end
            end
          end else if (imem_ready) begin
            pc_q    <= pend_pc_q;
            state_q <= FETCH_RUN;
          end
        end

        FETCH_ERROR: begin
          ifid_valid_q   <= 1'b0;
          ifid_instr_q   <= NOP_INSTR;
          is_flushed_q   <= 1'b0;
          misalign_err_q <= 1'b1;
        end

        default: begin
          state_q <= FETCH_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic,
// compared each cycle against a transaction-level model of the IF stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] KEY  = 32'hA5A5_A5A5;
  localparam int          M_RUN = 0, M_DRAIN = 1, M_ERR = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        flush;
  logic [31:0] branch_target, jal_target, jalr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid, is_flushed, misalign_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc, m_pend, m_ifid_pc, m_ifid_instr;
  logic        m_valid, m_flushed, m_err;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel        (pc_sel),
    .flush         (flush),
    .branch_target (branch_target),
    .jal_target    (jal_target),
    .jalr_target   (jalr_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .is_flushed    (is_flushed),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Memory returns a word tagged with its address so stale data is recognisable.
  assign imem_rdata = imem_addr ^ KEY;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] redirect_target(input logic [1:0] sel, input logic [31:0] pc,
                                                  input logic [31:0] br, input logic [31:0] jal,
                                                  input logic [31:0] jalr);
    case (sel)
      2'b01:   return br;
      2'b10:   return jal;
      2'b11:   return {jalr[31:1], 1'b0};
      default: return pc + 32'd4;
    endcase
  endfunction

  // Advance the model by one clock edge with the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = redirect_target(pc_sel, m_pc, branch_target, jal_target, jalr_target);
    if (rst) begin
      m_mode = M_RUN; m_pc = 32'h0; m_pend = 32'h0;
      m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_valid = 1'b0; m_flushed = 1'b0; m_err = 1'b0;
      return;
    end
    if (m_mode == M_ERR) begin
      m_valid = 1'b0; m_ifid_instr = NOP; m_flushed = 1'b0;
      return;
    end
    if (flush) begin
      m_valid = 1'b0; m_ifid_instr = NOP;
      if (tgt[1:0] != 2'b00) begin
        m_err = 1'b1; m_mode = M_ERR; m_flushed = 1'b0;
      end else begin
        m_flushed = 1'b1;
        if (imem_ready) begin m_pc = tgt; m_mode = M_RUN; end
        else begin m_pend = tgt; m_mode = M_DRAIN; end
      end
    end else if (m_mode == M_DRAIN) begin
      m_valid = 1'b0; m_ifid_instr = NOP; m_flushed = 1'b0;
      if (imem_ready) begin m_pc = m_pend; m_mode = M_RUN; end
    end else if (stall) begin
      // hold
    end else if (imem_ready) begin
      m_ifid_pc = m_pc; m_ifid_instr = m_pc ^ KEY; m_valid = 1'b1; m_flushed = 1'b0;
      m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0; m_ifid_instr = NOP; m_flushed = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("imem_req",     {31'b0, imem_req},     {31'b0, !rst && m_mode != M_ERR});
    check("imem_addr",    imem_addr,             m_pc);
    check("ifid_pc",      ifid_pc,               m_ifid_pc);
    check("ifid_instr",   ifid_instr,            m_ifid_instr);
    check("ifid_valid",   {31'b0, ifid_valid},   {31'b0, m_valid});
    check("is_flushed",   {31'b0, is_flushed},   {31'b0, m_flushed});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  // One clock: apply inputs mid-cycle, check combinational req/addr, clock, then check state.
  task automatic cyc(input logic r, input logic f, input logic [1:0] sel, input logic [31:0] br,
                     input logic [31:0] jal, input logic [31:0] jalr, input logic st, input logic rdy);
    rst = r; flush = f; pc_sel = sel; branch_target = br; jal_target = jal; jalr_target = jalr;
    stall = st; imem_ready = rdy;
    #1;
    if (!$isunknown(m_pc)) begin
      check("req_pre",  {31'b0, imem_req}, {31'b0, !rst && m_mode != M_ERR});
      check("addr_pre", imem_addr, m_pc);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    m_pc = 'x;
    rst = 1'b1; flush = 1'b0; pc_sel = 2'b00; stall = 1'b0; imem_ready = 1'b0;
    branch_target = '0; jal_target = '0; jalr_target = '0;
    @(negedge clk);

    // Sequential fetch 0,4,8,C then branch redirect at 0x10
    reset(2);
    run(4);
    check("pc_at_10", imem_addr, 32'h10);
    cyc(1'b0, 1'b1, 2'b01, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
    check("redir_40", imem_addr, 32'h40);
    check("flush_bubble", {30'b0, ifid_valid, is_flushed}, 32'b01);
    run(2);

    // JALR clears bit 0; misaligned JAL parks the unit until reset
    cyc(1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 32'h101, 1'b0, 1'b1);
    check("jalr_100", imem_addr, 32'h100);
    run(1);
    cyc(1'b0, 1'b1, 2'b10, 32'h0, 32'h102, 32'h0, 1'b0, 1'b1);
    run(3);
    check("err_req_low", {31'b0, imem_req}, 32'h0);

    // Flush while a request at 0x20 is stuck waiting for ready
    reset(1);
    run(8);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 32'h0, 32'h80, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("drain_hold_20", imem_addr, 32'h20);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("drain_to_80", imem_addr, 32'h80);
    run(2);

    // Stall holds IF/ID, then flush beats a simultaneous stall
    reset(1);
    run(3);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("stall_ifid_pc", ifid_pc, 32'h8);
    cyc(1'b0, 1'b1, 2'b01, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1);
    check("flush_over_stall", imem_addr, 32'h200);
    run(2);

    // PC wrap, then reset while draining discards the pending target
    cyc(1'b0, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
    run(1);
    check("pc_wrap", imem_addr, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
    reset(1);
    check("rst_in_drain", imem_addr, 32'h0);
    run(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, f, st, rdy;
      logic [1:0]  sel;
      logic [31:0] br, jal, jalr;
      r   = ($urandom_range(0, 99) < 2) || (m_mode == M_ERR && $urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 9) == 0);
      sel = 2'($urandom_range(0, 3));
      st  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      br   = {$urandom_range(0, 32'h3FFF), 2'b00};
      jal  = {$urandom_range(0, 32'h3FFF), 2'b00};
      jalr = {$urandom_range(0, 32'h3FFF), 1'b0, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 19) == 0) br[1:0]  = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) jal[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) jalr[1]  = 1'b1;
      cyc(r, f, sel, br, jal, jalr, st, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
